exc_sequencer: RTL
==================

Name: exc_sequencer

Overview:
Exception arbiter and entry sequencer for the five-stage core control path. Collects pending exception sources: reset, data abort, FIQ, IRQ, prefetch abort, undefined/coprocessor-absent and SWI. Picks one by fixed ARM priority, flushes and drains the pipeline for a programmable number of cycles, then presents the vector address and target mode to instruction fetch. Holds that presentation until fetch acknowledges the redirect.

Parameters:
VECTOR_BASE, 32'h0000_0000, base of the exception vector table.
DRAIN_CYCLES, 3, cycles spent in DRAIN after flush; legal range 1..15.
SYNC_STAGES, 2, synchronizer depth for nFIQ/nIRQ; 0 means inputs are already synchronous.

Ports:
nGCLK  in  1  core clock; all state updates on its rising edge.
nRESET  in  1  asynchronous, active-low reset.
nWAIT  in  1  low = global stall; all state, counters and outputs hold.
dabort_req  in  1  data abort pulse from ME.
iabort_req  in  1  prefetch-aborted instruction reached EX.
und_req  in  1  undefined or coprocessor-absent instruction in EX.
swi_req  in  1  SWI in EX.
nFIQ  in  1  fast interrupt, active-low, level.
nIRQ  in  1  interrupt, active-low, level.
fiq_disable  in  1  CPSR F bit.
irq_disable  in  1  CPSR I bit.
exc_ack  in  1  fetch has taken the vector.
flush  out  1  one-cycle kill of IF/ID/EX.
exc_valid  out  1  vector and mode valid.
exc_vector  out  32  vector address.
exc_mode  out  5  target CPSR mode.
exc_code  out  3  0 rst, 1 dabt, 2 fiq, 3 irq, 4 pabt, 5 und, 6 swi.
set_irq_disable  out  1  set I bit, pulsed with exc_ack.
set_fiq_disable  out  1  set F bit, pulsed with exc_ack (reset/FIQ only).
busy  out  1  state != IDLE.

Behaviour:
- States: RST_PEND, IDLE, FLUSH, DRAIN, VECTOR. Reset forces RST_PEND, and all outputs are 0 while nRESET is low. exc_code resets to 0.
- RST_PEND: on the first enabled edge after reset release, go to VECTOR with code 0. Reset uses VECTOR_BASE+0x00 and mode 10011.
- Pending bits:
  - dabt/pabt/und/swi are sticky once seen.
  - FIQ pending = synchronized !nFIQ & !fiq_disable; IRQ pending likewise. Both are re-evaluated every cycle and are not sticky.
- Priority: dabt > fiq > irq > pabt > und > swi.
- Table (offset, mode):
  - dabt 0x10, 10111
  - fiq 0x1C, 10001
  - irq 0x18, 10010
  - pabt 0x0C, 10111
  - und 0x04, 11011
  - swi 0x08, 10011
- IDLE: if any pending bit is set, latch the winner and go to FLUSH.
- FLUSH: flush=1 for exactly one cycle. Clear pabt/und/swi pending unless that source is the latched winner; the flushed instructions cannot raise them. Load the drain counter with DRAIN_CYCLES. Go to DRAIN.
- DRAIN: decrement the counter each enabled cycle. When it reaches 0:
  - If dabt is pending and the latched winner is lower priority, replace the winner with dabt, because an older instruction faulted.
  - Go to VECTOR.
- VECTOR: exc_valid=1, with vector/mode/code registered and stable. Hold until exc_ack=1.
  - On the ack edge, clear the winner's pending bit and pulse set_irq_disable=1 for one cycle.
  - Pulse set_fiq_disable for reset/FIQ.
  - Return to IDLE. New requests can be arbitrated the following cycle.
- Simultaneous events:
  - dabt_req and exc_ack in the same cycle: dabt stays pending and is serviced next.
  - A request arriving in FLUSH/DRAIN/VECTOR sets its pending bit. pabt/und/swi arriving after FLUSH are kept; they are from refetched instructions.
- nWAIT low in any state: freeze everything, including flush. flush is held high rather than re-pulsed.
- Reset mid-sequence: abort immediately; all pending bits are cleared.
- Latency: request in IDLE → flush next cycle → exc_valid 2+DRAIN_CYCLES cycles after the request edge.

Optional Feature:
HIGH_VECTORS_EN.
- Defined: adds input hivecs (1 bit). When hivecs=1, the base is 32'hFFFF_0000, otherwise VECTOR_BASE. hivecs is sampled when entering VECTOR.
- Undefined: no port, and the base is always VECTOR_BASE.

Test Plan:
- Release nRESET, nWAIT=1 → next edge exc_valid=1, vector 0x0, mode 10011, code 0. Ack → set_irq_disable=1 and set_fiq_disable=1 for one cycle, then IDLE.
- In IDLE, pulse swi_req → flush 1 cycle later; exc_valid after 3 drain cycles; vector 0x08, mode 10011; set_fiq_disable=0.
- nFIQ=0 and nIRQ=0 together, both enabled → FIQ taken (0x1C, mode 10001). After ack with nIRQ still low → IRQ taken (0x18).
- und_req taken; dabort_req pulsed during DRAIN → exc_valid shows 0x10, mode 10111, code 1. und is still pending after the ack and is serviced next (0x04).
- nFIQ=0 with fiq_disable=1 → no activity, busy=0. Hold nWAIT=0 during DRAIN for 5 cycles → counter frozen; exc_valid appears exactly DRAIN_CYCLES enabled cycles after flush.
- With HIGH_VECTORS_EN and hivecs=1, IRQ → exc_vector 0xFFFF0018. Assert nRESET mid-DRAIN → outputs 0; after release, reset vector is presented.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer: fixed-priority exception arbiter with flush/drain/vector entry sequencing.
// Optional macro HIGH_VECTORS_EN adds input hivecs selecting the 0xFFFF_0000 vector base.
module exc_sequencer #(
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        nGCLK,
  input  logic        nRESET,
  input  logic        nWAIT,
  input  logic        dabort_req,
  input  logic        iabort_req,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        nFIQ,
  input  logic        nIRQ,
  input  logic        fiq_disable,
  input  logic        irq_disable,
  input  logic        exc_ack,
`ifdef HIGH_VECTORS_EN
  input  logic        hivecs,
`endif
  output logic        flush,
  output logic        exc_valid,
  output logic [31:0] exc_vector,
  output logic [4:0]  exc_mode,
  output logic [2:0]  exc_code,
  output logic        set_irq_disable,
  output logic        set_fiq_disable,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_RST_PEND = 3'd0,
    S_IDLE     = 3'd1,
    S_FLUSH    = 3'd2,
    S_DRAIN    = 3'd3,
    S_VECTOR   = 3'd4
  } state_t;

  localparam logic [2:0] C_RST  = 3'd0;
  localparam logic [2:0] C_DABT = 3'd1;
  localparam logic [2:0] C_FIQ  = 3'd2;
  localparam logic [2:0] C_IRQ  = 3'd3;
  localparam logic [2:0] C_PABT = 3'd4;
  localparam logic [2:0] C_UND  = 3'd5;
  localparam logic [2:0] C_SWI  = 3'd6;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t      state, next_state;
  logic [2:0]  winner, next_winner;
  logic [3:0]  cnt, next_cnt;
  logic        pend_dabt, pend_pabt, pend_und, pend_swi;
  logic        pend_dabt_next, pend_pabt_next, pend_und_next, pend_swi_next;
  logic        fiq_n_s, irq_n_s, fiq_pend, irq_pend;
  logic        arb_any;
  logic [2:0]  arb_code;
  logic        ack_take, flush_clear, enter_vector;
  logic [31:0] base;

  // Synchronizers freeze with the rest of the core while nWAIT is low.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign fiq_n_s = nFIQ;
      assign irq_n_s = nIRQ;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] fiq_sr, irq_sr;
      always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
          fiq_sr <= '1;
          irq_sr <= '1;
        end else if (nWAIT) begin
          fiq_sr[0] <= nFIQ;
          irq_sr[0] <= nIRQ;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            fiq_sr[i] <= fiq_sr[i-1];
            irq_sr[i] <= irq_sr[i-1];
          end
        end
      end
      assign fiq_n_s = fiq_sr[SYNC_STAGES-1];
      assign irq_n_s = irq_sr[SYNC_STAGES-1];
    end
  endgenerate

  assign fiq_pend  = ~fiq_n_s & ~fiq_disable;
  assign irq_pend  = ~irq_n_s & ~irq_disable;
  assign fsm_state = state;

`ifdef HIGH_VECTORS_EN
  assign base = hivecs ? 32'hFFFF_0000 : VECTOR_BASE;
`else
  assign base = VECTOR_BASE;
`endif

  function automatic logic [31:0] vec_offset(input logic [2:0] code);
    case (code)
      C_DABT:  vec_offset = 32'h10;
      C_FIQ:   vec_offset = 32'h1C;
      C_IRQ:   vec_offset = 32'h18;
      C_PABT:  vec_offset = 32'h0C;
      C_UND:   vec_offset = 32'h04;
      C_SWI:   vec_offset = 32'h08;
      default: vec_offset = 32'h00;
    endcase
  endfunction

  function automatic logic [4:0] vec_mode(input logic [2:0] code);
    case (code)
      C_DABT:  vec_mode = 5'b10111;
      C_FIQ:   vec_mode = 5'b10001;
      C_IRQ:   vec_mode = 5'b10010;
      C_PABT:  vec_mode = 5'b10111;
      C_UND:   vec_mode = 5'b11011;
      default: vec_mode = 5'b10011;
    endcase
  endfunction

  // Priority follows code order: dabt > fiq > irq > pabt > und > swi.
  always_comb begin
    arb_any  = 1'b1;
    arb_code = C_RST;
    if (pend_dabt)      arb_code = C_DABT;
    else if (fiq_pend)  arb_code = C_FIQ;
    else if (irq_pend)  arb_code = C_IRQ;
    else if (pend_pabt) arb_code = C_PABT;
    else if (pend_und)  arb_code = C_UND;
    else if (pend_swi)  arb_code = C_SWI;
    else                arb_any  = 1'b0;
  end

  // exc_valid/exc_ack: exc_valid rises with vector, mode and code stable and stays
  // high until an enabled edge samples exc_ack high; that edge completes the transfer.
  always_comb begin
    next_state  = state;
    next_winner = winner;
    next_cnt    = cnt;
    case (state)
      S_RST_PEND: begin
        next_state  = S_VECTOR;
        next_winner = C_RST;
      end
      S_IDLE: begin
        if (arb_any) begin
          next_state  = S_FLUSH;
          next_winner = arb_code;
        end
      end
      S_FLUSH: begin
        next_state = S_DRAIN;
        next_cnt   = DRAIN_LOAD;
      end
      S_DRAIN: begin
        if (cnt <= 4'd1) begin
          next_cnt   = 4'd0;
          next_state = S_VECTOR;
          if ((pend_dabt | dabort_req) && (winner > C_DABT)) next_winner = C_DABT;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      S_VECTOR: begin
        if (exc_ack) next_state = S_IDLE;
      end
      default: next_state = S_RST_PEND;
    endcase
  end

  // New requests win over the ack clear; the flush clear wins over requests from killed slots.
  always_comb begin
    ack_take       = (state == S_VECTOR) && exc_ack;
    flush_clear    = (state == S_FLUSH);
    enter_vector   = (next_state == S_VECTOR) && (state != S_VECTOR);
    pend_dabt_next = (pend_dabt & ~(ack_take && winner == C_DABT)) | dabort_req;
    pend_pabt_next = (flush_clear && winner != C_PABT) ? 1'b0 :
                     ((pend_pabt & ~(ack_take && winner == C_PABT)) | iabort_req);
    pend_und_next  = (flush_clear && winner != C_UND) ? 1'b0 :
                     ((pend_und & ~(ack_take && winner == C_UND)) | und_req);
    pend_swi_next  = (flush_clear && winner != C_SWI) ? 1'b0 :
                     ((pend_swi & ~(ack_take && winner == C_SWI)) | swi_req);
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) state <= S_RST_PEND;
    else if (nWAIT) state <= next_state;
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      winner          <= C_RST;
      cnt             <= 4'd0;
      pend_dabt       <= 1'b0;
      pend_pabt       <= 1'b0;
      pend_und        <= 1'b0;
      pend_swi        <= 1'b0;
      flush           <= 1'b0;
      exc_valid       <= 1'b0;
      exc_vector      <= 32'd0;
      exc_mode        <= 5'd0;
      exc_code        <= 3'd0;
      set_irq_disable <= 1'b0;
      set_fiq_disable <= 1'b0;
      busy            <= 1'b0;
    end else if (nWAIT) begin
      winner          <= next_winner;
      cnt             <= next_cnt;
      pend_dabt       <= pend_dabt_next;
      pend_pabt       <= pend_pabt_next;
      pend_und        <= pend_und_next;
      pend_swi        <= pend_swi_next;
      flush           <= (next_state == S_FLUSH);
      exc_valid       <= (next_state == S_VECTOR);
      busy            <= (next_state != S_IDLE);
      set_irq_disable <= ack_take;
      set_fiq_disable <= ack_take && (winner == C_RST || winner == C_FIQ);
      if (enter_vector) begin
        exc_vector <= base + vec_offset(next_winner);
        exc_mode   <= vec_mode(next_winner);
        exc_code   <= next_winner;
      end
    end
  end

endmodule
